logica_comb_de_entrada: RTL and testbench

- Next-state (input combinational) logic block of the 2-bit Mealy FSM "consecutive-ones tracker".
- Takes the FSM input w and the present state bits y1 (MSB) and y2 (LSB), and produces the next-state bits Yout1/Yout2 that feed the state register.
- The clock and reset drive only a small supervisory register, which flags the unused state code, plus the optional registered output stage.

---
 rtl/logica_comb_de_entrada.sv | 106 ++++++++++
 tb/tb_logica_comb_de_entrada.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/logica_comb_de_entrada.sv
// -----------------------------------------------------------------------------
// logica_comb_de_entrada
//
// Purpose:
//   Next-state (input combinational) logic for the 2-bit Mealy FSM
//   "consecutive-ones tracker". Given the FSM input w and the present state
//   {y1,y2}, it produces the next-state bits {Yout1,Yout2} that feed the
//   external state register.
//
//   State encoding {y1,y2}:
//     S0 = 00  no 1s seen
//     S1 = 01  one 1 seen
//     S2 = 10  two or more consecutive 1s seen
//     11       unused; always recovers to S0
//
//   Next-state equations:
//     Yout1 = w & (y1 ^ y2)
//     Yout2 = w & ~y1 & ~y2
//
//   A small supervisory register raises a sticky flag when the unused code 11
//   is sampled on a rising clock edge.
//
// Configuration macro:
//   LOGICA_COMB_REG_OUT_EN
//     undefined (default) : Yout1/Yout2 are purely combinational, zero
//                           latency, independent of clk and reset.
//     defined             : Yout1/Yout2 come from a register capturing the
//                           equations on each rising clk (1-cycle latency);
//                           synchronous reset forces them to 00 (S0).
//
// Ports:
//   clk           in   1  system clock, rising-edge active
//   reset         in   1  synchronous, active-high reset
//   w             in   1  FSM input bit
//   y1            in   1  present-state bit, MSB
//   y2            in   1  present-state bit, LSB
//   Yout1         out  1  next-state bit, MSB (Y1)
//   Yout2         out  1  next-state bit, LSB (Y2)
//   illegal_state out  1  sticky flag: present state 11 was sampled
// -----------------------------------------------------------------------------
module logica_comb_de_entrada (
  input  logic clk,
  input  logic reset,
  input  logic w,
  input  logic y1,
  input  logic y2,
  output logic Yout1,
  output logic Yout2,
  output logic illegal_state
);

  // ---------------------------------------------------------------------------
  // Next-state equations. The 11 code yields 00 for either w because
  // y1 ^ y2 = 0 and ~y1 & ~y2 = 0, which gives the self-recovery to S0.
  // ---------------------------------------------------------------------------
  logic w_y1_next;
  logic w_y2_next;
  logic w_is_unused;

  assign w_y1_next   = w & (y1 ^ y2);
  assign w_y2_next   = w & ~y1 & ~y2;
  assign w_is_unused = y1 & y2;

  // ---------------------------------------------------------------------------
  // Supervisory sticky flag. Reset is checked first so that a reset coinciding
  // with an unused-code sample leaves the flag cleared.
  // ---------------------------------------------------------------------------
  logic r_illegal_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal_state <= 1'b0;
    end else if (w_is_unused) begin
      r_illegal_state <= 1'b1;
    end
  end

  assign illegal_state = r_illegal_state;

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef LOGICA_COMB_REG_OUT_EN
  logic r_yout1;
  logic r_yout2;

  // Registered outputs: reset returns the presented next state to S0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_yout1 <= 1'b0;
      r_yout2 <= 1'b0;
    end else begin
      r_yout1 <= w_y1_next;
      r_yout2 <= w_y2_next;
    end
  end

  assign Yout1 = r_yout1;
  assign Yout2 = r_yout2;
`else
  // Combinational outputs: no dependence on clk, reset or the flag register.
  assign Yout1 = w_y1_next;
  assign Yout2 = w_y2_next;
`endif

endmodule

// File: tb/tb_logica_comb_de_entrada.sv
// -----------------------------------------------------------------------------
// Testbench for logica_comb_de_entrada. Works for both the default build and
// the LOGICA_COMB_REG_OUT_EN build.
// -----------------------------------------------------------------------------
module tb_logica_comb_de_entrada;

  logic clk;
  logic reset;
  logic w;
  logic y1;
  logic y2;
  logic Yout1;
  logic Yout2;
  logic illegal_state;

  int n_checks;
  int n_pass;

  typedef struct {
    logic       w;
    logic       y1;
    logic       y2;
    logic [1:0] exp_y;
  } vec_t;

  vec_t vecs [8];

  logic [1:0] walk_w_exp [4];
  logic [3:0] walk_w;
  logic [1:0] st;
  logic [1:0] nxt;

  logica_comb_de_entrada dut (
    .clk           (clk),
    .reset         (reset),
    .w             (w),
    .y1            (y1),
    .y2            (y2),
    .Yout1         (Yout1),
    .Yout2         (Yout2),
    .illegal_state (illegal_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("check %-22s got %b expected %b ok", name, act, exp);
    end else begin
      $display("FAIL %-22s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Truth table: {w,y1,y2} -> {Yout1,Yout2}
    vecs[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 2'b00};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b00};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 2'b00};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 2'b00};

    // Sequence walk stimulus and expected successive states
    walk_w        = 4'b0111;   // bit i is w for step i: 1,1,1,0
    walk_w_exp[0] = 2'b01;
    walk_w_exp[1] = 2'b10;
    walk_w_exp[2] = 2'b10;
    walk_w_exp[3] = 2'b00;

    reset = 1'b1;
    w     = 1'b0;
    y1    = 1'b0;
    y2    = 1'b0;
    tick();
    check("reset_illegal", {1'b0, illegal_state}, 2'b00);
`ifdef LOGICA_COMB_REG_OUT_EN
    check("reset_yout", {Yout1, Yout2}, 2'b00);
`endif
    reset = 1'b0;

    // ---------------- Truth table sweep ----------------
    for (int i = 0; i < 8; i++) begin
      w  = vecs[i].w;
      y1 = vecs[i].y1;
      y2 = vecs[i].y2;
`ifdef LOGICA_COMB_REG_OUT_EN
      tick();
`else
      #1;
`endif
      check($sformatf("table_%0d%0d%0d", vecs[i].w, vecs[i].y1, vecs[i].y2),
            {Yout1, Yout2}, vecs[i].exp_y);
    end

    // Table visited 011 and 111: the sticky flag is expected set now.
    tick();
    check("flag_after_sweep", {1'b0, illegal_state}, 2'b01);

    // ---------------- Illegal-state flag sequence ----------------
    reset = 1'b1; w = 1'b0; y1 = 1'b0; y2 = 1'b0;
    tick();
    reset = 1'b0;
    check("flag_cleared", {1'b0, illegal_state}, 2'b00);
    y1 = 1'b1; y2 = 1'b1;
    tick();
    check("flag_set", {1'b0, illegal_state}, 2'b01);
    y1 = 1'b0; y2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("flag_sticky_%0d", k), {1'b0, illegal_state}, 2'b01);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("flag_reset_clears", {1'b0, illegal_state}, 2'b00);

    // ---------------- Reset priority over set ----------------
    reset = 1'b1; y1 = 1'b1; y2 = 1'b1;
    tick();
    check("reset_priority", {1'b0, illegal_state}, 2'b00);
`ifndef LOGICA_COMB_REG_OUT_EN
    // Combinational outputs ignore reset.
    w = 1'b1; y1 = 1'b0; y2 = 1'b0;
    #1;
    check("yout_during_reset", {Yout1, Yout2}, 2'b01);
`endif
    reset = 1'b0; w = 1'b0; y1 = 1'b0; y2 = 1'b0;
    tick();

`ifndef LOGICA_COMB_REG_OUT_EN
    // ---------------- Sequence walk with bench state register ----------------
    st = 2'b00;
    for (int s = 0; s < 4; s++) begin
      w  = walk_w[s];
      y1 = st[1];
      y2 = st[0];
      #1;
      nxt = {Yout1, Yout2};
      tick();
      st = nxt;
      check($sformatf("walk_step_%0d", s), st, walk_w_exp[s]);
    end
`else
    // ---------------- Registered output latency ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reg_reset_yout", {Yout1, Yout2}, 2'b00);
    w = 1'b1; y1 = 1'b0; y2 = 1'b0;
    #1;
    check("reg_before_edge", {Yout1, Yout2}, 2'b00);
    tick();
    check("reg_after_edge_s1", {Yout1, Yout2}, 2'b01);
    w = 1'b1; y1 = 1'b0; y2 = 1'b1;
    tick();
    check("reg_after_edge_s2", {Yout1, Yout2}, 2'b10);
    tick();
    check("reg_hold_s2", {Yout1, Yout2}, 2'b10);
    // Reset mid-operation with inputs still requesting S2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reg_midop_reset", {Yout1, Yout2}, 2'b00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
